// File: rtl/rgb_hue_pwm.sv
// Colour-wheel hue sequencer driving three brightness-scaled PWM LED channels.
// The hue walks six segments of a linear ramp; duties are latched once per PWM period.
module rgb_hue_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] bright,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic [2:0]          segment,
  output logic                wrap
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    MODE_FWD   = 2'b00,
    MODE_HOLD  = 2'b01,
    MODE_REV   = 2'b10,
    MODE_WHITE = 2'b11
  } mode_t;

  mode_t cur_mode;
  logic [SW-1:0] step_cnt;
  logic tick;
  logic [PWM_BITS-1:0] ramp;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] lvl_r, lvl_g, lvl_b;
  logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
  logic [PWM_BITS-1:0] lat_r, lat_g, lat_b;
  logic [PWM_BITS:0] gain;
  logic on_r, on_g, on_b;

  assign cur_mode = mode_t'(mode);
  assign tick     = en && (step_cnt == STEP_LAST);
  assign gain     = {1'b0, bright} + {{PWM_BITS{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (en) begin
      step_cnt <= tick ? '0 : step_cnt + SW'(1);
    end
  end

  // Hue position advances or retreats one ramp step per tick; hold and white freeze it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp    <= '0;
      segment <= 3'd0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (tick) begin
        case (cur_mode)
          MODE_FWD: begin
            if (ramp == MAX) begin
              ramp    <= '0;
              segment <= (segment == 3'd5) ? 3'd0 : segment + 3'd1;
              wrap    <= (segment == 3'd5);
            end else begin
              ramp <= ramp + PWM_BITS'(1);
            end
          end
          MODE_REV: begin
            if (ramp == '0) begin
              ramp    <= MAX;
              segment <= (segment == 3'd0) ? 3'd5 : segment - 3'd1;
              wrap    <= (segment == 3'd0);
            end else begin
              ramp <= ramp - PWM_BITS'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    lvl_r = '0;
    lvl_g = '0;
    lvl_b = '0;
    if (cur_mode == MODE_WHITE) begin
      lvl_r = MAX;
      lvl_g = MAX;
      lvl_b = MAX;
    end else begin
      case (segment)
        3'd0: begin lvl_r = MAX;        lvl_g = ramp;       lvl_b = '0;         end
        3'd1: begin lvl_r = MAX - ramp; lvl_g = MAX;        lvl_b = '0;         end
        3'd2: begin lvl_r = '0;         lvl_g = MAX;        lvl_b = ramp;       end
        3'd3: begin lvl_r = '0;         lvl_g = MAX - ramp; lvl_b = MAX;        end
        3'd4: begin lvl_r = ramp;       lvl_g = '0;         lvl_b = MAX;        end
        3'd5: begin lvl_r = MAX;        lvl_g = '0;         lvl_b = MAX - ramp; end
        default: ;
      endcase
    end
  end

  // Full-width product keeps level=MAX, bright=MAX mapping exactly to MAX.
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] level,
                                               input logic [PWM_BITS:0]   g);
    logic [2*PWM_BITS:0] prod;
    prod = {{(PWM_BITS+1){1'b0}}, level} * {{PWM_BITS{1'b0}}, g};
    return PWM_BITS'(prod >> PWM_BITS);
  endfunction

  assign duty_r = scale(lvl_r, gain);
  assign duty_g = scale(lvl_g, gain);
  assign duty_b = scale(lvl_b, gain);

  // Duties are only sampled at the end of a period so a running period is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      lat_r   <= '0;
      lat_g   <= '0;
      lat_b   <= '0;
      on_r    <= 1'b0;
      on_g    <= 1'b0;
      on_b    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == MAX) begin
        lat_r <= duty_r;
        lat_g <= duty_g;
        lat_b <= duty_b;
      end
      on_r <= (pwm_cnt < lat_r);
      on_g <= (pwm_cnt < lat_g);
      on_b <= (pwm_cnt < lat_b);
    end
  end

  assign RGB_R = on_r ^ INV;
  assign RGB_G = on_g ^ INV;
  assign RGB_B = on_b ^ INV;

endmodule

// File: tb/tb_rgb_hue_pwm.sv
// Bench for rgb_hue_pwm: a hue-position/PWM-period model checked every cycle,
// plus directed scenarios with hand-computed counts.
module tb_rgb_hue_pwm;

  localparam int PB   = 4;
  localparam int SC   = 2;
  localparam int MAXV = 15;
  localparam int NPOS = 96;

  logic clk = 1'b0;
  logic rst, rst_al, en;
  logic [1:0] mode;
  logic [PB-1:0] bright;

  logic r_m, g_m, b_m, wrap_m;
  logic [2:0] seg_m;
  logic r_s, g_s, b_s, wrap_s;
  logic [2:0] seg_s;
  logic r_a, g_a, b_a, wrap_a;
  logic [2:0] seg_a;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int cyc;
  int m_step, m_pos, m_pcnt, m_wrap;
  int m_duty[3];
  int m_act[3];

  rgb_hue_pwm #(.PWM_BITS(PB), .STEP_CYCLES(SC), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .bright(bright),
    .RGB_R(r_m), .RGB_G(g_m), .RGB_B(b_m), .segment(seg_m), .wrap(wrap_m));

  rgb_hue_pwm #(.PWM_BITS(PB), .STEP_CYCLES(1000), .ACTIVE_LOW(0)) u_dut_slow (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .bright(bright),
    .RGB_R(r_s), .RGB_G(g_s), .RGB_B(b_s), .segment(seg_s), .wrap(wrap_s));

  rgb_hue_pwm #(.PWM_BITS(PB), .STEP_CYCLES(SC), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst(rst_al), .en(en), .mode(mode), .bright(bright),
    .RGB_R(r_a), .RGB_G(g_a), .RGB_B(b_a), .segment(seg_a), .wrap(wrap_a));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                               input logic [PB-1:0] br);
    rst    = r;
    en     = e;
    mode   = m;
    bright = br;
  endtask

  // Raw channel level of a hue position (segment*16 + ramp).
  function automatic int levelOf(input int pos, input int ch, input bit white);
    int s, rr;
    int lv[3];
    if (white) return MAXV;
    s  = pos / 16;
    rr = pos % 16;
    case (s)
      0: lv = '{MAXV, rr, 0};
      1: lv = '{MAXV - rr, MAXV, 0};
      2: lv = '{0, MAXV, rr};
      3: lv = '{0, MAXV - rr, MAXV};
      4: lv = '{rr, 0, MAXV};
      default: lv = '{MAXV, 0, MAXV - rr};
    endcase
    return lv[ch];
  endfunction

  // Reference behaviour of the main instance, one update per clock edge.
  always @(posedge clk) begin
    bit tk;
    if (rst) begin
      cyc = 0; m_step = 0; m_pos = 0; m_pcnt = 0; m_wrap = 0;
      for (int i = 0; i < 3; i++) begin m_duty[i] = 0; m_act[i] = 0; end
    end else begin
      cyc++;
      for (int i = 0; i < 3; i++) m_act[i] = (m_pcnt < m_duty[i]) ? 1 : 0;
      if (m_pcnt == MAXV)
        for (int i = 0; i < 3; i++)
          m_duty[i] = (levelOf(m_pos, i, mode == 2'b11) * (int'(bright) + 1)) >> PB;
      m_pcnt = (m_pcnt + 1) % 16;
      tk = en && (m_step == SC - 1);
      if (en) m_step = (m_step + 1) % SC;
      m_wrap = 0;
      if (tk && mode == 2'b00) begin
        m_wrap = (m_pos == NPOS - 1) ? 1 : 0;
        m_pos  = (m_pos + 1) % NPOS;
      end else if (tk && mode == 2'b10) begin
        m_wrap = (m_pos == 0) ? 1 : 0;
        m_pos  = (m_pos + NPOS - 1) % NPOS;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst && cmp_en) begin
      checkOutput("model_R", int'(r_m), m_act[0]);
      checkOutput("model_G", int'(g_m), m_act[1]);
      checkOutput("model_B", int'(b_m), m_act[2]);
      checkOutput("model_segment", int'(seg_m), m_pos / 16);
      checkOutput("model_wrap", int'(wrap_m), m_wrap);
    end
  end

  // Count active-high cycles over 16 samples: sel 0 main, 1 slow, 2 active-low (counts lows).
  task automatic sampleWindow(input int sel, output int hr, output int hg, output int hb);
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (sel)
        0: begin hr += int'(r_m); hg += int'(g_m); hb += int'(b_m); end
        1: begin hr += int'(r_s); hg += int'(g_s); hb += int'(b_s); end
        default: begin hr += int'(!r_a); hg += int'(!g_a); hb += int'(!b_a); end
      endcase
    end
  endtask

  initial begin
    int hr, hg, hb, sr, sg, sb, wraps, nseq, found;
    int seq[8];
    bit seq_ok;

    rst_al = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b00, 4'd15);
    repeat (3) @(negedge clk);
    checkOutput("reset_R", int'(r_m), 0);
    checkOutput("reset_G", int'(g_m), 0);
    checkOutput("reset_B", int'(b_m), 0);
    checkOutput("reset_segment", int'(seg_m), 0);
    checkOutput("reset_wrap", int'(wrap_m), 0);
    checkOutput("reset_al_R", int'(r_a), 1);

    // Forward run from reset: full wheel in 192 cycles, slow instance shows first period.
    cmp_en = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd15);
    rst_al = 1'b0;
    sr = 0; sg = 0; sb = 0; wraps = 0; nseq = 1; seq[0] = 0;
    for (int k = 1; k <= 192; k++) begin
      @(negedge clk);
      if (k >= 17 && k <= 32) begin
        sr += int'(r_s); sg += int'(g_s); sb += int'(b_s);
      end
      wraps += int'(wrap_m);
      if (int'(seg_m) != seq[nseq-1] && nseq < 8) begin
        seq[nseq] = int'(seg_m);
        nseq++;
      end
    end
    checkOutput("slow_first_period_R", sr, 15);
    checkOutput("slow_first_period_G", sg, 0);
    checkOutput("slow_first_period_B", sb, 0);
    checkOutput("fwd_wrap_at_192", int'(wrap_m), 1);
    checkOutput("fwd_wrap_count", wraps, 1);
    checkOutput("fwd_segment_192", int'(seg_m), 0);
    checkOutput("fwd_seq_length", nseq, 7);
    seq_ok = 1'b1;
    for (int i = 0; i < 7; i++) if (seq[i] != i % 6) seq_ok = 1'b0;
    checkOutput("fwd_seq_order", int'(seq_ok), 1);

    // Reverse from reset: first tick wraps to segment 5 / ramp 15, then freeze.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'd15);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'd15);
    repeat (2) @(negedge clk);
    checkOutput("rev_segment", int'(seg_m), 5);
    checkOutput("rev_wrap", int'(wrap_m), 1);
    en = 1'b0;
    repeat (40) @(negedge clk);
    sampleWindow(0, hr, hg, hb);
    checkOutput("rev_R_duty", hr, 15);
    checkOutput("rev_G_duty", hg, 0);
    checkOutput("rev_B_duty", hb, 0);

    // White at bright 7: duty (15*8)>>4 = 7, hue frozen.
    applyStimulus(1'b0, 1'b1, 2'b11, 4'd7);
    repeat (40) @(negedge clk);
    sampleWindow(0, hr, hg, hb);
    checkOutput("white_R", hr, 7);
    checkOutput("white_G", hg, 7);
    checkOutput("white_B", hb, 7);
    checkOutput("white_segment", int'(seg_m), 5);

    // Forward with en=0: hue frozen, PWM still running.
    applyStimulus(1'b0, 1'b0, 2'b00, 4'd15);
    repeat (40) @(negedge clk);
    checkOutput("en0_segment", int'(seg_m), 5);
    sampleWindow(0, hr, hg, hb);
    checkOutput("en0_R", hr, 15);
    checkOutput("en0_B", hb, 0);

    // Brightness drop at pwm_cnt=5 finishes the running period at the old duty.
    applyStimulus(1'b0, 1'b0, 2'b11, 4'd15);
    repeat (40) @(negedge clk);
    found = 0;
    for (int i = 0; i < 32 && found == 0; i++) begin
      @(negedge clk);
      if (cyc % 16 == 5) found = 1;
    end
    checkOutput("bright_phase_found", found, 1);
    bright = 4'd0;
    sampleWindow(0, hr, hg, hb);
    checkOutput("bright_old_period_R", hr, 10);
    checkOutput("bright_old_period_G", hg, 10);
    sampleWindow(0, hr, hg, hb);
    checkOutput("bright_new_period_R", hr, 0);
    checkOutput("bright_new_period_B", hb, 0);

    // Active-low instance: async reset mid-period, then no partial pulse.
    bright = 4'd15;
    repeat (40) @(negedge clk);
    found = 0;
    for (int i = 0; i < 32 && found == 0; i++) begin
      @(negedge clk);
      if (r_a == 1'b0) found = 1;
    end
    checkOutput("al_active_before_reset", found, 1);
    rst_al = 1'b1;
    #1;
    checkOutput("al_async_R", int'(r_a), 1);
    checkOutput("al_async_G", int'(g_a), 1);
    checkOutput("al_async_B", int'(b_a), 1);
    repeat (2) @(negedge clk);
    rst_al = 1'b0;
    sampleWindow(2, hr, hg, hb);
    checkOutput("al_no_partial_pulse", hr + hg + hb, 0);
    repeat (20) @(negedge clk);
    sampleWindow(2, hr, hg, hb);
    checkOutput("al_running_R", hr, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
